// File: rtl/cart_flash_ctrl.sv
// Cartridge flash read controller sitting behind the MMU.
// Runs timed read cycles on a parallel flash, stretches the Z80 cycle via wait_n,
// and holds the captured byte on rd_data. Flash is read-only: writes are absorbed.
// Optional one-entry read cache enabled by defining CART_CACHE_EN.
module cart_flash_ctrl #(
  parameter int unsigned ACCESS_CYCLES   = 4,
  parameter int unsigned RST_HOLD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [21:0] addr,
  output logic [7:0]  rd_data,
  output logic        wait_n,
  inout  wire  [7:0]  FL_DQ,
  output logic [21:0] FL_ADDR,
  output logic        FL_OE_N,
  output logic        FL_CE_N,
  output logic        FL_WE_N,
  output logic        FL_RST_N
);

  localparam logic [3:0] AccLoad = 4'(ACCESS_CYCLES - 1);
  localparam logic [7:0] RstLoad = 8'(RST_HOLD_CYCLES);

  typedef enum logic [2:0] {StRst, StIdle, StSetup, StAccess, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic [21:0] fl_addr_q, fl_addr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ce_n_q, oe_n_q, fl_rst_n_q;
  logic        capture;
  logic        cache_hit;
  logic [7:0]  cache_data;
  logic        hold_match;
  logic        unused_wr;

  // Writes never stall the bus and never start a cycle.
  assign unused_wr = wr;

`ifdef CART_CACHE_EN
  logic [21:0] tag_q;
  logic [7:0]  cdata_q;
  logic        valid_q;

  assign cache_hit  = (state_q == StIdle) && rd && valid_q && (addr == tag_q);
  assign cache_data = cdata_q;

  // Every completed flash capture refreshes the single cache entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q   <= '0;
      cdata_q <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      tag_q   <= fl_addr_q;
      cdata_q <= FL_DQ;
      valid_q <= 1'b1;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 8'h00;
`endif

  assign hold_match = (state_q == StHold) && (addr == fl_addr_q);

  // Stall is combinational so the Z80 sees it in the same cycle rd rises.
  assign wait_n = !(rd && !(hold_match || cache_hit));

  // Next-state, counters, address latch and data capture.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    acc_cnt_d = acc_cnt_q;
    fl_addr_d = fl_addr_q;
    rd_data_d = rd_data_q;
    capture   = 1'b0;
    unique case (state_q)
      StRst: begin
        if (rst_cnt_q <= 8'd1) begin
          rst_cnt_d = 8'd0;
          state_d   = StIdle;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      StIdle: begin
        if (cache_hit) begin
          rd_data_d = cache_data;
          fl_addr_d = addr;
          state_d   = StHold;
        end else if (rd) begin
          fl_addr_d = addr;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (!rd) begin
          state_d = StIdle;
        end else begin
          acc_cnt_d = AccLoad;
          state_d   = StAccess;
        end
      end
      StAccess: begin
        if (!rd) begin
          state_d = StIdle;
        end else if (acc_cnt_q == 4'd0) begin
          rd_data_d = FL_DQ;
          capture   = 1'b1;
          state_d   = StHold;
        end else begin
          acc_cnt_d = acc_cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (!rd) begin
          state_d = StIdle;
        end else if (addr != fl_addr_q) begin
          // Back-to-back read: straight to SETUP without an idle cycle.
          fl_addr_d = addr;
          state_d   = StSetup;
        end
      end
      default: state_d = StRst;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StRst;
      rst_cnt_q <= RstLoad;
      acc_cnt_q <= '0;
      fl_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      fl_addr_q <= fl_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Flash strobes registered from the next state: glitch-free, low exactly in ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      fl_rst_n_q <= 1'b0;
    end else begin
      ce_n_q     <= (state_d != StAccess);
      oe_n_q     <= (state_d != StAccess);
      fl_rst_n_q <= (state_d != StRst);
    end
  end

  assign rd_data  = rd_data_q;
  assign FL_ADDR  = fl_addr_q;
  assign FL_CE_N  = ce_n_q;
  assign FL_OE_N  = oe_n_q;
  assign FL_RST_N = fl_rst_n_q;
  assign FL_WE_N  = 1'b1;

endmodule

// File: tb/tb_cart_flash_ctrl.sv
// Self-checking bench for cart_flash_ctrl: reset hold, single/back-to-back reads,
// abort, write ignore and the optional CART_CACHE_EN repeated-read path.
module tb_cart_flash_ctrl;

`ifdef CART_CACHE_EN
  localparam int CacheLat = 0;
`else
  localparam int CacheLat = 6;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [21:0] addr = '0;
  logic [7:0]  rd_data;
  logic        wait_n;
  wire  [7:0]  fl_dq;
  logic [21:0] fl_addr;
  logic        fl_oe_n, fl_ce_n, fl_we_n, fl_rst_n;

  cart_flash_ctrl #(
    .ACCESS_CYCLES  (4),
    .RST_HOLD_CYCLES(32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .rd_data (rd_data),
    .wait_n  (wait_n),
    .FL_DQ   (fl_dq),
    .FL_ADDR (fl_addr),
    .FL_OE_N (fl_oe_n),
    .FL_CE_N (fl_ce_n),
    .FL_WE_N (fl_we_n),
    .FL_RST_N(fl_rst_n)
  );

  always #10 clk = ~clk;

  // Flash content model: fixed bytes at the test addresses, hash elsewhere.
  function automatic logic [7:0] flash_byte(input logic [21:0] a);
    case (a)
      22'h000010: flash_byte = 8'hA5;
      22'h3FFFFF: flash_byte = 8'h3C;
      22'h000001: flash_byte = 8'h5A;
      default:    flash_byte = a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h96;
    endcase
  endfunction

  assign fl_dq = flash_byte(fl_addr);

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [21:0] a;
    logic        w;
    logic [7:0]  data;
    int          lat;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the stall to end, then pops and compares the scoreboard entry.
  task automatic wait_done(input string name);
    exp_t e;
    int   n;
    int   ce_low;
    int   we_bad;
    n = 0;
    ce_low = 0;
    we_bad = 0;
    while (wait_n !== 1'b1 && n < 100) begin
      if (!fl_ce_n) ce_low++;
      if (fl_we_n !== 1'b1) we_bad++;
      step();
      n++;
    end
    e = sb.pop_front();
    check({name, " latency"}, n, e.lat);
    check({name, " data"}, rd_data, e.data);
    check({name, " ce_low"}, ce_low, (e.lat == 0) ? 0 : 4);
    check({name, " we_n"}, we_bad, 0);
  endtask

  // Starts a read from IDLE and checks the stall in the rd-rise cycle.
  task automatic do_read(input logic [21:0] a, input logic w, input logic [7:0] d,
                         input int lat, input string name);
    addr = a;
    wr   = w;
    rd   = 1'b1;
    sb.push_back('{data: d, lat: lat});
    #1;
    check({name, " wait_n at rise"}, wait_n, (lat == 0) ? 1 : 0);
    wait_done(name);
  endtask

  task automatic release_rd();
    rd = 1'b0;
    wr = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rst_low;
    int ce_low;
    int oe_low;
    exp_t e;

    tbl[0] = '{a: 22'h000000, w: 1'b0, data: 8'h96, lat: 6};
    tbl[1] = '{a: 22'h2AAAAA, w: 1'b0, data: 8'hBC, lat: 6};
    tbl[2] = '{a: 22'h155555, w: 1'b0, data: 8'h83, lat: 6};
    tbl[3] = '{a: 22'h3FFFFE, w: 1'b0, data: 8'hA8, lat: 6};
    tbl[4] = '{a: 22'h000300, w: 1'b1, data: 8'h95, lat: 6};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset rd_data", rd_data, 8'h00);
    check("reset fl_addr", fl_addr, 22'h0);
    check("reset ce_n/oe_n/we_n", {fl_ce_n, fl_oe_n, fl_we_n}, 3'b111);
    check("reset fl_rst_n", fl_rst_n, 1'b0);

    // Read requested straight out of reset: waits for flash reset plus a full read.
    reset_n = 1'b1;
    addr = 22'h000010;
    rd = 1'b1;
    sb.push_back('{data: 8'hA5, lat: 38});
    #1;
    n = 0;
    rst_low = 0;
    ce_low = 0;
    oe_low = 0;
    while (wait_n !== 1'b1 && n < 200) begin
      if (!fl_rst_n) rst_low++;
      if (!fl_ce_n) ce_low++;
      if (!fl_oe_n) oe_low++;
      step();
      n++;
    end
    e = sb.pop_front();
    check("rst hold cycles", rst_low, 32);
    check("post-reset ce_low", ce_low, 4);
    check("post-reset oe_low", oe_low, 4);
    check("post-reset latency", n, e.lat);
    check("post-reset data", rd_data, e.data);
    release_rd();

    // Single read at the top of the address space.
    do_read(22'h3FFFFF, 1'b0, 8'h3C, 6, "single");
    check("single fl_addr", fl_addr, 22'h3FFFFF);
    release_rd();

    // Abort on the second ACCESS cycle.
    addr = 22'h000100;
    rd = 1'b1;
    step();
    step();
    step();
    check("abort in access", fl_ce_n, 1'b0);
    rd = 1'b0;
    step();
    check("abort ce_n/oe_n", {fl_ce_n, fl_oe_n}, 2'b11);
    check("abort rd_data", rd_data, 8'h3C);
    check("abort wait_n", wait_n, 1'b1);

    // Table-driven reads, rd toggled between entries.
    foreach (tbl[i]) begin
      do_read(tbl[i].a, tbl[i].w, tbl[i].data, tbl[i].lat, $sformatf("vec%0d", i));
      release_rd();
    end

    // Back-to-back: address changes while held in HOLD.
    do_read(22'h3FFFFF, 1'b0, 8'h3C, 6, "b2b first");
    addr = 22'h000001;
    sb.push_back('{data: 8'h5A, lat: 6});
    #1;
    check("b2b wait_n drop", wait_n, 1'b0);
    wait_done("b2b second");
    check("b2b fl_addr", fl_addr, 22'h000001);
    release_rd();

    // Writes alone never stall or strobe.
    addr = 22'h000200;
    wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("write ignore", {wait_n, fl_ce_n, fl_oe_n, fl_we_n}, 4'hF);
    end
    do_read(22'h000200, 1'b1, 8'h94, 6, "rd+wr");
    release_rd();

    // Repeated read of the same address.
    do_read(22'h000010, 1'b0, 8'hA5, 6, "repeat first");
    release_rd();
    do_read(22'h000010, 1'b0, 8'hA5, CacheLat, "repeat second");
    step();
    step();
    check("repeat ce_n after", fl_ce_n, 1'b1);
    check("repeat rd_data after", rd_data, 8'hA5);
    release_rd();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
